// File: rtl/msg_writer.sv
// -----------------------------------------------------------------------------
// msg_writer
//
// Six-entry character message buffer driven by two raw pushbuttons.
// Each button is synchronised (2 flops) and debounced. A debounced press
// (released -> pressed) on the write key appends char_in. A press on the
// delete key blanks the newest entry. Entries that are not valid always
// read as 3'b100 (blank).
//
// Optional feature, enabled by defining MSG_WRITER_OVERWRITE_EN:
//   A write while full shifts the buffer down, dropping the oldest entry,
//   instead of being rejected with the sticky overflow flag.
//
// Ports
//   clk        in   single clock
//   resetn     in   asynchronous active-low reset
//   char_in    in   [2:0] character code (000 d, 001 E, 010 1, 011 0, 1xx blank)
//   wr_key_n   in   raw write pushbutton, active-low, asynchronous
//   del_key_n  in   raw delete pushbutton, active-low, asynchronous
//   clr        in   synchronous buffer clear, active-high
//   msg        out  [17:0] entry k on [3k+2:3k], entry 0 oldest
//   count      out  [2:0] number of valid entries (0..6)
//   empty      out  count == 0
//   full       out  count == 6
//   wr_ack     out  one-cycle pulse per accepted write
//   overflow   out  sticky flag, set by a rejected write
// -----------------------------------------------------------------------------
module msg_writer #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [2:0]  char_in,
    input  logic        wr_key_n,
    input  logic        del_key_n,
    input  logic        clr,
    output logic [17:0] msg,
    output logic [2:0]  count,
    output logic        empty,
    output logic        full,
    output logic        wr_ack,
    output logic        overflow
);

    // The counter only has to reach DEBOUNCE_CYCLES-1: the level flips on
    // the cycle it would otherwise wrap.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0] BLANK = 3'b100;
    localparam logic [2:0] DEPTH = 3'd6;

    // Key index 0 = write, 1 = delete
    logic [1:0]       raw_keys;
    logic [1:0]       sync1_q, sync2_q;
    logic [1:0]       db_q, db_d;
    logic [1:0]       db_prev_q;
    logic [1:0]       armed_q, armed_d;
    logic [1:0]       warm_q, warm_d;
    logic [CNT_W-1:0] cnt_q [0:1];
    logic [CNT_W-1:0] cnt_d [0:1];
    logic [1:0]       press;
    logic             wr_ev, del_ev;

    logic [2:0]       entry_q [0:5];
    logic [2:0]       entry_d [0:5];
    logic [2:0]       count_q, count_d;
    logic             wr_ack_q, wr_ack_d;
    logic             overflow_q, overflow_d;

    assign raw_keys = {del_key_n, wr_key_n};

    // ------------------------------------------------------------------
    // Synchronisers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
        end else begin
            sync1_q <= raw_keys;
            sync2_q <= sync1_q;
        end
    end

    // ------------------------------------------------------------------
    // Debounce and press arming
    //
    // warm_q[1] is set once sync2_q holds a real sample of the key rather
    // than its reset value. A key is armed only after it has been seen
    // released since reset. A key held down through reset therefore does
    // not count as a press until it is released and pressed again.
    // ------------------------------------------------------------------
    always_comb begin
        db_d    = db_q;
        armed_d = armed_q;
        warm_d  = {warm_q[0], 1'b1};
        for (int k = 0; k < 2; k++) begin
            cnt_d[k] = '0;
            // Any cycle where the synced level agrees with the debounced
            // level (a bounce) restarts the count from zero.
            if (sync2_q[k] != db_q[k]) begin
                if (cnt_q[k] == CNT_LAST) begin
                    db_d[k] = sync2_q[k];
                end else begin
                    cnt_d[k] = cnt_q[k] + CNT_W'(1);
                end
            end
            if (warm_q[1] && sync2_q[k]) begin
                armed_d[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            db_q      <= 2'b11;
            db_prev_q <= 2'b11;
            armed_q   <= 2'b00;
            warm_q    <= 2'b00;
            cnt_q[0]  <= '0;
            cnt_q[1]  <= '0;
        end else begin
            db_q      <= db_d;
            db_prev_q <= db_q;
            armed_q   <= armed_d;
            warm_q    <= warm_d;
            cnt_q[0]  <= cnt_d[0];
            cnt_q[1]  <= cnt_d[1];
        end
    end

    // Press event: debounced falling edge on an armed key, one cycle long
    assign press  = armed_q & db_prev_q & ~db_q;
    assign wr_ev  = press[0];
    assign del_ev = press[1];

    // ------------------------------------------------------------------
    // Buffer update. Priority: clr, then delete (discards a same-cycle
    // write), then write.
    // ------------------------------------------------------------------
    always_comb begin
        for (int k = 0; k < 6; k++) begin
            entry_d[k] = entry_q[k];
        end
        count_d    = count_q;
        wr_ack_d   = 1'b0;
        overflow_d = overflow_q;

        if (clr) begin
            for (int k = 0; k < 6; k++) begin
                entry_d[k] = BLANK;
            end
            count_d    = 3'd0;
            overflow_d = 1'b0;
        end else if (del_ev) begin
            if (count_q != 3'd0) begin
                for (int k = 0; k < 6; k++) begin
                    if (3'(k) == count_q - 3'd1) begin
                        entry_d[k] = BLANK;
                    end
                end
                count_d = count_q - 3'd1;
            end
        end else if (wr_ev) begin
            if (count_q < DEPTH) begin
                for (int k = 0; k < 6; k++) begin
                    if (3'(k) == count_q) begin
                        entry_d[k] = char_in;
                    end
                end
                count_d  = count_q + 3'd1;
                wr_ack_d = 1'b1;
            end else begin
`ifdef MSG_WRITER_OVERWRITE_EN
                for (int k = 0; k < 5; k++) begin
                    entry_d[k] = entry_q[k+1];
                end
                entry_d[5] = char_in;
                wr_ack_d   = 1'b1;
`else
                overflow_d = 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < 6; k++) begin
                entry_q[k] <= BLANK;
            end
            count_q    <= 3'd0;
            wr_ack_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            for (int k = 0; k < 6; k++) begin
                entry_q[k] <= entry_d[k];
            end
            count_q    <= count_d;
            wr_ack_q   <= wr_ack_d;
            overflow_q <= overflow_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        msg = '0;
        for (int k = 0; k < 6; k++) begin
            msg[3*k +: 3] = entry_q[k];
        end
    end

    assign count    = count_q;
    assign empty    = (count_q == 3'd0);
    assign full     = (count_q == DEPTH);
    assign wr_ack   = wr_ack_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_msg_writer.sv
// -----------------------------------------------------------------------------
// tb_msg_writer
//
// Bench for msg_writer with DEBOUNCE_CYCLES = 4. The expected buffer is a
// queue of characters (oldest first) plus a sticky overflow bit. A settled
// key press takes effect 3 + DEBOUNCE_CYCLES = 7 clock edges after the
// raw key goes low.
// -----------------------------------------------------------------------------
module tb_msg_writer;

    localparam int DB  = 4;
    localparam int LAT = 3 + DB;

    logic        clk;
    logic        resetn;
    logic [2:0]  char_in;
    logic        wr_key_n;
    logic        del_key_n;
    logic        clr;
    logic [17:0] msg;
    logic [2:0]  count;
    logic        empty;
    logic        full;
    logic        wr_ack;
    logic        overflow;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [2:0] model_q[$];
    logic       model_ovf;

    msg_writer #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .char_in   (char_in),
        .wr_key_n  (wr_key_n),
        .del_key_n (del_key_n),
        .clr       (clr),
        .msg       (msg),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .wr_ack    (wr_ack),
        .overflow  (overflow)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] model_msg();
        logic [17:0] m;
        m = '0;
        for (int k = 0; k < 6; k++) begin
            m[3*k +: 3] = (k < model_q.size()) ? model_q[k] : 3'b100;
        end
        return m;
    endfunction

    task automatic check_state(input string tag, input logic exp_ack);
        check({tag, ":msg"},      32'(msg),      32'(model_msg()));
        check({tag, ":count"},    32'(count),    32'(model_q.size()));
        check({tag, ":empty"},    32'(empty),    32'(model_q.size() == 0));
        check({tag, ":full"},     32'(full),     32'(model_q.size() == 6));
        check({tag, ":overflow"}, 32'(overflow), 32'(model_ovf));
        check({tag, ":wr_ack"},   32'(wr_ack),   32'(exp_ack));
    endtask

    // Behavioural effect of one update cycle
    task automatic model_apply(input logic wr, input logic del, input logic use_clr,
                               input logic [2:0] ch, output logic ack);
        ack = 1'b0;
        if (use_clr) begin
            model_q.delete();
            model_ovf = 1'b0;
        end else if (del) begin
            if (model_q.size() > 0) void'(model_q.pop_back());
        end else if (wr) begin
            if (model_q.size() < 6) begin
                model_q.push_back(ch);
                ack = 1'b1;
            end else begin
`ifdef MSG_WRITER_OVERWRITE_EN
                void'(model_q.pop_front());
                model_q.push_back(ch);
                ack = 1'b1;
`else
                model_ovf = 1'b1;
`endif
            end
        end
    endtask

    // Press the selected key(s), optionally pulse clr in the update cycle,
    // hold for 'hold' extra cycles, then release.
    task automatic do_op(input logic wr, input logic del, input logic use_clr,
                         input logic [2:0] ch, input int hold);
        logic ack;
        char_in = 3'($urandom_range(0, 7));   // only the update-cycle value matters
        if (wr)  wr_key_n  = 1'b0;
        if (del) del_key_n = 1'b0;
        steps(LAT - 1);
        check_state("pre", 1'b0);
        char_in = ch;
        if (use_clr) clr = 1'b1;
        step();
        clr = 1'b0;
        model_apply(wr, del, use_clr, ch, ack);
        check_state("post", ack);
        step();
        check("ack_drop", 32'(wr_ack), 32'd0);
        steps(hold);
        check_state("held", 1'b0);
        wr_key_n  = 1'b1;
        del_key_n = 1'b1;
        steps(LAT + 1);
        check_state("release", 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic ack;
        resetn    = 1'b0;
        char_in   = 3'd0;
        wr_key_n  = 1'b1;
        del_key_n = 1'b1;
        clr       = 1'b0;
        model_ovf = 1'b0;

        // Reset state
        #12;
        check_state("reset", 1'b0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        steps(5);
        check_state("idle", 1'b0);

        // First write, key held long afterwards: exactly one write
        do_op(1'b1, 1'b0, 1'b0, 3'b000, 12);

        // Bouncing write key: low 2, high 1, then low stable
        char_in  = 3'b111;
        wr_key_n = 1'b0;
        steps(2);
        wr_key_n = 1'b1;
        step();
        wr_key_n = 1'b0;
        steps(LAT - 1);
        check_state("bounce_pre", 1'b0);
        char_in = 3'b001;
        step();
        model_apply(1'b1, 1'b0, 1'b0, 3'b001, ack);
        check_state("bounce_post", ack);
        step();
        check("bounce_ack_drop", 32'(wr_ack), 32'd0);
        wr_key_n = 1'b1;
        steps(LAT + 1);
        check_state("bounce_rel", 1'b0);

        // Fill to full
        do_op(1'b1, 1'b0, 1'b0, 3'b010, 0);
        do_op(1'b1, 1'b0, 1'b0, 3'b011, 0);
        do_op(1'b1, 1'b0, 1'b0, 3'b100, 0);
        do_op(1'b1, 1'b0, 1'b0, 3'b100, 0);
        check("full_flag", 32'(full), 32'd1);

        // Seventh write while full
        do_op(1'b1, 1'b0, 1'b0, 3'b001, 0);

        // Down to three entries, then simultaneous write + delete
        do_op(1'b0, 1'b1, 1'b0, 3'b000, 0);
        do_op(1'b0, 1'b1, 1'b0, 3'b000, 0);
        do_op(1'b0, 1'b1, 1'b0, 3'b000, 0);
        do_op(1'b1, 1'b1, 1'b0, 3'b011, 0);

        // Up to four entries, then clr in the same cycle as a write event
        do_op(1'b1, 1'b0, 1'b0, 3'b010, 0);
        do_op(1'b1, 1'b0, 1'b0, 3'b001, 0);
        check("count_before_clr", 32'(count), 32'd4);
        do_op(1'b1, 1'b0, 1'b1, 3'b011, 0);

        // Delete on an empty buffer
        do_op(1'b0, 1'b1, 1'b0, 3'b000, 0);

        // Random operations
        for (int i = 0; i < 14; i++) begin
            int op;
            op = int'($urandom_range(0, 4));
            case (op)
                0, 1, 2: do_op(1'b1, 1'b0, 1'b0, 3'($urandom_range(0, 7)), 0);
                3:       do_op(1'b0, 1'b1, 1'b0, 3'($urandom_range(0, 7)), 0);
                default: do_op(1'b1, 1'b1, 1'b0, 3'($urandom_range(0, 7)), 0);
            endcase
        end

        // Reset in the middle of a debounce, key held through release
        wr_key_n = 1'b0;
        steps(4);
        resetn = 1'b0;
        #2;
        model_q.delete();
        model_ovf = 1'b0;
        check_state("rst_mid", 1'b0);
        steps(2);
        check_state("rst_hold", 1'b0);
        resetn = 1'b1;
        steps(20);
        check_state("held_thru_rst", 1'b0);
        wr_key_n = 1'b1;
        steps(LAT + 1);
        check_state("released_after_rst", 1'b0);
        do_op(1'b1, 1'b0, 1'b0, 3'b010, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/msg_writer.md
MSG_WRITER -- requirements
Module: msg_writer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, SHALL set the number of consecutive stable cycles a key needs before it is accepted (20 ms at 50 MHz).
REQ-002 Port clk, input, 1 bit, SHALL be the single clock (CLOCK_50 at top level).
REQ-003 Port resetn, input, 1 bit, SHALL be the reset: asynchronous, active-low.
REQ-004 Port char_in, input, 3 bits, SHALL carry the character code to write (000 d, 001 E, 010 1, 011 0, 1xx blank).
REQ-005 Port wr_key_n, input, 1 bit, SHALL be the raw write pushbutton (active-low, asynchronous to clk).
REQ-006 Port del_key_n, input, 1 bit, SHALL be the raw delete pushbutton (active-low, asynchronous to clk).
REQ-007 Port clr, input, 1 bit, SHALL be a synchronous active-high buffer clear.
REQ-008 Port msg, output, 18 bits, SHALL expose entry k on bits [3k+2:3k], with entry 0 the oldest.
REQ-009 Port count, output, 3 bits, SHALL give the number of valid entries (0..6).
REQ-010 Ports empty and full, outputs, 1 bit each, SHALL assert when count==0 and count==6 respectively.
REQ-011 Port wr_ack, output, 1 bit, SHALL pulse for one cycle on each accepted write.
REQ-012 Port overflow, output, 1 bit, SHALL be a sticky flag for a rejected write.

Function
REQ-013 Each key SHALL pass through a 2-flop synchronizer, then a debounce counter; the debounced level SHALL update only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles, and any bounce SHALL restart the count.
REQ-014 A press event SHALL be a debounced 1->0 transition only; releases and held keys SHALL produce no further events.
REQ-015 The buffer SHALL update on the clock edge after the press event, i.e. 3+DEBOUNCE_CYCLES edges after the raw key settles low.
REQ-016 A write with count<6 SHALL store char_in (sampled in the update cycle) at entry[count], increment count and pulse wr_ack.
REQ-017 A delete with count>0 SHALL set entry[count-1] to 100 (blank) and decrement count; a delete with count==0 SHALL have no effect.
REQ-018 Simultaneous write and delete events SHALL execute the delete and discard the write, with no wr_ack and no overflow.
REQ-019 clr SHALL, on the next edge, set all entries to 100, count to 0 and overflow to 0, and SHALL take priority over same-cycle key events.
REQ-020 Entries at index >= count SHALL always read 100.
REQ-021 count SHALL never exceed 6 nor underflow below 0.

Reset
REQ-022 While resetn is low: all entries 100, count 0, empty 1, full 0, wr_ack 0, overflow 0, synchronizer and debounced levels 1 (released), debounce counters 0.
REQ-023 Reset asserted mid-debounce SHALL discard the pending event; a key held low through reset release SHALL register as a press only after it is seen released and then pressed again.

Configuration
REQ-024 With macro MSG_WRITER_OVERWRITE_EN defined, a write while full SHALL shift entries down by one (dropping entry 0), store char_in at entry 5, keep count at 6, pulse wr_ack, and leave overflow unchanged.
REQ-025 Without MSG_WRITER_OVERWRITE_EN, a write while full SHALL leave the buffer unchanged, produce no wr_ack and set overflow to 1.

Verification (DEBOUNCE_CYCLES=4)
REQ-026 Reset, then char_in=000 and wr_key_n held low -> 7 edges later entry0=000, count=1, one wr_ack pulse, and no further writes while the key is held.
REQ-027 wr_key_n bounces (low 2 cycles, high 1, low stable) -> exactly one write, landing 7 edges after the final falling edge.
REQ-028 Write 000,001,010,011,100,100, then a seventh write -> full=1; without the macro: overflow=1, msg unchanged; with the macro: entries shift and entry5=char_in.
REQ-029 count=3, both keys pressed in the same cycle -> count=2, entry2=100, no wr_ack.
REQ-030 count=4 and clr pulsed in the same cycle as a write event -> count=0, msg=all 100, overflow=0.
REQ-031 resetn pulsed low mid-debounce with wr_key_n held low -> no write after release of reset until the key is released and pressed again.
